// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: timing bundle from the VGA sync generator to the RGB path.
// frame_cnt exists only when VGA_SYNC_FRAME_CNT_EN is defined.
interface vga_sync_gen_if;
    logic       p_tick;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       line_tick;
    logic       frame_tick;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    modport master (
        output p_tick, pix_x, pix_y, video_on,
        output hsync, vsync, line_tick, frame_tick
`ifdef VGA_SYNC_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        input p_tick, pix_x, pix_y, video_on,
        input hsync, vsync, line_tick, frame_tick
`ifdef VGA_SYNC_FRAME_CNT_EN
        , input frame_cnt
`endif
    );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-tick divider, h/v position counters and sync decodes.
// Define VGA_SYNC_FRAME_CNT_EN to add the 16-bit frame counter.
module vga_sync_gen #(
    parameter int CLK_DIV = 2,
    parameter int H_DISP  = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_DISP  = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISP);
    localparam logic [9:0] V_VIS    = 10'(V_DISP);
    localparam logic [9:0] HS_FIRST = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_DISP + V_FP + V_SYNC - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL/V_TOTAL must be <= 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_sync_gen: CLK_DIV must be 1..16");
    end

    logic [3:0] div_q, div_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       p_tick;
    logic       h_last;
    logic       v_last;
    logic       line_tick;
    logic       frame_tick;

    // With CLK_DIV=1 div_q stays 0 and the compare holds p_tick at 1.
    always_comb begin
        p_tick = (div_q == DIV_LAST);
        h_last = (x_q == H_LAST);
        v_last = (y_q == V_LAST);
        div_d  = p_tick ? 4'd0 : div_q + 4'd1;
        x_d    = x_q;
        y_d    = y_q;
        if (p_tick) begin
            x_d = h_last ? 10'd0 : x_q + 10'd1;
            if (h_last) begin
                y_d = v_last ? 10'd0 : y_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= 4'd0;
            x_q   <= 10'd0;
            y_q   <= 10'd0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    assign line_tick  = p_tick & h_last;
    assign frame_tick = line_tick & v_last;

    assign vga.p_tick     = p_tick;
    assign vga.pix_x      = x_q;
    assign vga.pix_y      = y_q;
    assign vga.video_on   = (x_q < H_VIS) && (y_q < V_VIS);
    assign vga.hsync      = !((x_q >= HS_FIRST) && (x_q <= HS_LAST));
    assign vga.vsync      = !((y_q >= VS_FIRST) && (y_q <= VS_LAST));
    assign vga.line_tick  = line_tick;
    assign vga.frame_tick = frame_tick;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q + {15'd0, frame_tick};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign vga.frame_cnt = frame_cnt_q;
`endif
endmodule
